// File: rtl/issue_queue_rr.sv
// ============================================================================
//  Module   : issue_queue_rr
//  Purpose  : In-order issue queue feeding arithmetic/branch reservation
//             stations and the ROB. Define IQ_RR_ALLOC_EN for round-robin
//             station allocation; otherwise fixed lowest-index priority.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package tomasula_types;
    // BRANCH is encoded as zero so an all-zero word reads as the empty default.
    typedef enum logic [2:0] {
        BRANCH = 3'd0,
        ADD    = 3'd1,
        SUB    = 3'd2,
        AND_OP = 3'd3,
        OR_OP  = 3'd4,
        SHL    = 3'd5,
        SHR    = 3'd6,
        MUL    = 3'd7
    } opcode_t;

    typedef struct packed {
        opcode_t     op;
        logic [4:0]  dest;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [15:0] imm;
    } ctl_word;
endpackage

module issue_queue_rr
    import tomasula_types::*;
#(
    parameter int DEPTH  = 8,
    parameter int NUM_RS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       ld_iq,
    input  tomasula_types::ctl_word    control_i,
    output logic                       ack_o,
    output logic                       issue_q_full_n,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    input  logic [NUM_RS-1:0]          rs_empty,
    input  logic                       resbr_empty,
    input  logic                       rob_full,
    output logic [NUM_RS-1:0]          rs_load,
    output logic                       resbr_load,
    output logic                       rob_load,
    output tomasula_types::ctl_word    control_o
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    ctl_word              r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_is_br;
    logic                 w_can_issue;
    logic                 w_deq;
    logic [NUM_RS-1:0]    w_grant;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_CNT_W'(DEPTH));

    // A full queue refuses new work even when the head pops this cycle.
    assign ack_o          = ld_iq & ~w_full & ~flush & ~rst;
    assign issue_q_full_n = ~w_full;
    assign count_o        = r_count;

    always_comb begin
        control_o = r_mem[r_head];
        if (w_empty) begin
            control_o    = '0;
            control_o.op = BRANCH;
        end
    end

    assign w_is_br     = (control_o.op == BRANCH);
    assign w_can_issue = ~w_empty & ~rob_full & ~flush & ~rst;
    assign w_deq       = w_can_issue & (w_is_br ? resbr_empty : (|rs_empty));

    assign resbr_load  = w_deq & w_is_br;
    assign rob_load    = w_deq;
    assign rs_load     = (w_deq & ~w_is_br) ? w_grant : '0;

`ifdef IQ_RR_ALLOC_EN
    logic [c_IDX_W-1:0]   r_last;
    logic [c_IDX_W-1:0]   w_grant_idx;

    // Search begins one past the last granted station and wraps.
    always_comb begin : p_alloc
        int   idx;
        logic found;
        w_grant     = '0;
        w_grant_idx = '0;
        found       = 1'b0;
        idx         = 0;
        for (int k = 0; k < NUM_RS; k++) begin
            idx = (int'(r_last) + 1 + k) % NUM_RS;
            if (!found && rs_empty[c_IDX_W'(idx)]) begin
                found                  = 1'b1;
                w_grant[c_IDX_W'(idx)] = 1'b1;
                w_grant_idx            = c_IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= c_IDX_W'(NUM_RS - 1);
        end else if (w_deq && !w_is_br) begin
            r_last <= w_grant_idx;
        end
    end
`else
    always_comb begin : p_alloc
        logic found;
        w_grant = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_RS; k++) begin
            if (!found && rs_empty[c_IDX_W'(k)]) begin
                found                = 1'b1;
                w_grant[c_IDX_W'(k)] = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (ack_o) begin
            r_mem[r_tail] <= control_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (ack_o) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            if (w_deq) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            case ({ack_o, w_deq})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire
